rom_fetch_arbiter: RTL and testbench
====================================

# rom_fetch_arbiter

Sequencer and arbiter for the byte-wide boot ROM mapped at 0xBFC00000–0xBFC00FFF. It accepts 32-bit word read requests from two requesters, the instruction-fetch port and the data-load port. For each accepted request it issues four byte reads to a single-ported ROM with one-cycle synchronous read latency, assembles the word, and returns it to the granted requester. It sits between the fetch/load stages and the ROM array, and replaces direct combinational ROM reads.

## Interface
- ADDR_BASE, 32'hBFC00000, byte address of ROM offset 0
- ROM_BYTES, 4096, ROM size in bytes (power of two)
- DATA_WIDTH, 8, ROM data width (bits per byte location)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request (level)
- if_addr  in  32  fetch byte address
- ld_req  in  1  load request (level)
- ld_addr  in  32  load byte address
- mem_en  out  1  ROM read enable
- mem_addr  out  log2(ROM_BYTES)  ROM byte offset
- mem_rdata  in  DATA_WIDTH  ROM byte, valid the cycle after mem_en/mem_addr
- rsp_rdata  out  32  assembled word, shared by both ports
- if_valid  out  1  one-cycle fetch response strobe
- if_err  out  1  fetch address out of range, qualified by if_valid
- ld_valid  out  1  one-cycle load response strobe
- ld_err  out  1  load address out of range, qualified by ld_valid
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, READ, DONE, ERR. Reset state is IDLE.
- Reset values: mem_en=0, mem_addr=0, rsp_rdata=0, all valid/err=0, busy=0, byte counter=0, last_grant=LOAD.
- Requests are sampled only in IDLE. Requesters hold req and addr until their valid strobe.
- Arbitration in IDLE:
  - Single requester: it is granted.
  - Both requesting: grant the port not recorded in last_grant.
  - last_grant updates on every grant. After reset, fetch wins the first tie.
- Address handling:
  - Word address = {addr[31:2],2'b00}; low two bits are ignored.
  - In range iff ADDR_BASE ≤ word address ≤ ADDR_BASE+ROM_BYTES−4.
  - Offset = word address − ADDR_BASE, truncated to mem_addr width.
- In range: IDLE→READ. The counter k steps 0..3 and drives mem_addr=offset+k with mem_en=1. The byte returned for offset+k lands in rsp_rdata[31−8k -: 8], so the lowest address is the most significant byte. After the fourth byte is captured: →DONE.
- DONE: the granted port's valid is high for one cycle with err=0 and rsp_rdata holding the word. Next state is IDLE.
- Out of range: IDLE→ERR. No mem_en is issued. In ERR, the granted port's valid=1, err=1, rsp_rdata=0. Next state is IDLE.
- Deasserting req mid-transaction has no effect; the transaction completes and responds.
- rsp_rdata holds its value until the next transaction starts assembling.
- Asserting rst_n low mid-transaction clears all state immediately. The in-flight request is abandoned with no response. Held requests are re-arbitrated after reset release.

## Timing
- Cycle 0: IDLE samples req and grants.
- Cycles 1–4: mem_en=1, mem_addr=offset+0..+3.
- Cycles 2–5: mem_rdata captured at the end of each cycle.
- Cycle 6: valid strobe (DONE).
- Cycle 7: IDLE, the earliest next accept. Throughput is one word per 7 cycles.
- Error path: grant in cycle 0, valid+err in cycle 1, IDLE in cycle 2.
- All outputs are registered; there are no combinational paths from req or addr to outputs.
- busy is high from cycle 1 through the response cycle inclusive.

## Test plan
- Single fetch: ROM offsets 0x010–0x013 = 11,22,33,44; if_addr=0xBFC00010 → mem_addr 0x010..0x013 in cycles 1–4; if_valid in cycle 6 with rsp_rdata=0x11223344, if_err=0.
- Unaligned fetch: if_addr=0xBFC00013 → same accesses and rsp_rdata=0x11223344.
- Contention: both requests held from reset release → order fetch, load, fetch, load. Each response arrives 7 cycles after the previous one, and no valid strobe coincides with another.
- Range boundaries: ld_addr=0xBFC00FFC → mem_addr 0xFFC..0xFFF, ld_err=0. ld_addr=0xBFC01000 or 0x00000000 → ld_valid+ld_err in cycle 1, rsp_rdata=0, mem_en never asserted.
- Reset mid-read: assert rst_n low during cycle 3 of a fetch → all outputs 0 asynchronously, no if_valid. After release with if_req still high, a full 6-cycle transaction completes normally.
- Request drop: deassert if_req in cycle 2 → the transaction still completes with if_valid in cycle 6, then the block stays IDLE.

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// Arbitrates fetch/load word reads onto a byte-wide boot ROM with one-cycle read latency,
// assembling four big-endian bytes into a 32-bit response for the granted port.
module rom_fetch_arbiter #(
    parameter logic [31:0] ADDR_BASE  = 32'hBFC00000,
    parameter int          ROM_BYTES  = 4096,
    parameter int          DATA_WIDTH = 8,
    localparam int         AW         = $clog2(ROM_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    input  logic                  ld_req,
    input  logic [31:0]           ld_addr,
    output logic                  mem_en,
    output logic [AW-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           rsp_rdata,
    output logic                  if_valid,
    output logic                  if_err,
    output logic                  ld_valid,
    output logic                  ld_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic        GRANT_IF  = 1'b0;
    localparam logic        GRANT_LD  = 1'b1;
    localparam logic [31:0] LAST_WORD = ADDR_BASE + 32'(ROM_BYTES) - 32'd4;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            last_grant_q, last_grant_d;
    logic            mem_en_q, mem_en_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            if_err_q, if_err_d;
    logic            ld_valid_q, ld_valid_d;
    logic            ld_err_q, ld_err_d;
    logic            busy_q, busy_d;

    logic            pick_s;
    logic [31:0]     req_addr_s;
    logic [31:0]     word_s;
    logic [AW-1:0]   off_s;
    logic            in_range_s;

    // Grant selection and address decode of the candidate request
    always_comb begin
        pick_s = GRANT_IF;
        if (if_req && ld_req) begin
            pick_s = ~last_grant_q;
        end else if (ld_req) begin
            pick_s = GRANT_LD;
        end else begin
            pick_s = GRANT_IF;
        end
        req_addr_s = (pick_s == GRANT_LD) ? ld_addr : if_addr;
        word_s     = req_addr_s & ~32'd3;
        off_s      = AW'(word_s - ADDR_BASE);
        in_range_s = (word_s >= ADDR_BASE) && (word_s <= LAST_WORD);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        rdata_d      = rdata_q;
        if_valid_d   = 1'b0;
        if_err_d     = 1'b0;
        ld_valid_d   = 1'b0;
        ld_err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req || ld_req) begin
                    last_grant_d = pick_s;
                    if (in_range_s) begin
                        state_d    = ST_READ;
                        cnt_d      = 3'd0;
                        mem_en_d   = 1'b1;
                        mem_addr_d = off_s;
                    end else begin
                        state_d    = ST_ERR;
                        rdata_d    = 32'd0;
                        if_valid_d = (pick_s == GRANT_IF);
                        if_err_d   = (pick_s == GRANT_IF);
                        ld_valid_d = (pick_s == GRANT_LD);
                        ld_err_d   = (pick_s == GRANT_LD);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // cnt_q counts issued bytes; the byte issued one cycle earlier arrives now
                case (cnt_q)
                    3'd1:    rdata_d[31:24] = mem_rdata;
                    3'd2:    rdata_d[23:16] = mem_rdata;
                    3'd3:    rdata_d[15:8]  = mem_rdata;
                    3'd4:    rdata_d[7:0]   = mem_rdata;
                    default: rdata_d        = rdata_q;
                endcase
                if (cnt_q < 3'd3) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = mem_addr_q + {{(AW-1){1'b0}}, 1'b1};
                end else begin
                    mem_en_d   = 1'b0;
                end
                if (cnt_q == 3'd4) begin
                    state_d    = ST_DONE;
                    cnt_d      = 3'd0;
                    if_valid_d = (last_grant_q == GRANT_IF);
                    ld_valid_d = (last_grant_q == GRANT_LD);
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= GRANT_LD;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            rdata_q      <= 32'd0;
            if_valid_q   <= 1'b0;
            if_err_q     <= 1'b0;
            ld_valid_q   <= 1'b0;
            ld_err_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            rdata_q      <= rdata_d;
            if_valid_q   <= if_valid_d;
            if_err_q     <= if_err_d;
            ld_valid_q   <= ld_valid_d;
            ld_err_q     <= ld_err_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_rdata = rdata_q;
    assign if_valid  = if_valid_q;
    assign if_err    = if_err_q;
    assign ld_valid  = ld_valid_q;
    assign ld_err    = ld_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter: a ROM model feeds the DUT and a queue of
// expected responses is checked as each valid strobe appears.
module tb_rom_fetch_arbiter;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [31:0] rsp_rdata;
    logic        if_valid;
    logic        if_err;
    logic        ld_valid;
    logic        ld_err;
    logic        busy;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  rom [0:4095];
    int          tests = 0;
    int          fails = 0;

    rom_fetch_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_rdata (rsp_rdata),
        .if_valid  (if_valid),
        .if_err    (if_err),
        .ld_valid  (ld_valid),
        .ld_err    (ld_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= rom[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [11:0] off);
        return {rom[off], rom[off + 12'd1], rom[off + 12'd2], rom[off + 12'd3]};
    endfunction

    task automatic push_exp(input bit port, input logic [31:0] addr, input bit err);
        exp_t e;
        e.port = port;
        e.err  = err;
        e.data = err ? 32'd0 : word_at(addr[11:0] & 12'hFFC);
        sb.push_back(e);
    endtask

    task automatic check_rsp();
        exp_t e;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        check("valid_excl", 32'(if_valid & ld_valid), 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_port", 32'(ld_valid), 32'(e.port));
            check("rsp_err", 32'(e.port ? ld_err : if_err), 32'(e.err));
            check("rsp_rdata", rsp_rdata, e.data);
        end
    endtask

    task automatic drop_reqs();
        if_req = 1'b0;
        ld_req = 1'b0;
    endtask

    // One transaction starting this cycle (cycle 0); follows it to its response
    task automatic txn(input bit port, input logic [31:0] addr, input bit exp_err, input int drop_c);
        int          c;
        bit          seen;
        logic [31:0] off;
        off = 32'(addr[11:0] & 12'hFFC);
        push_exp(port, addr, exp_err);
        if (port) begin
            ld_req = 1'b1; ld_addr = addr;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        seen = 1'b0;
        c = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (!exp_err && c <= 4) begin
                check("mem_en_on", 32'(mem_en), 32'd1);
                check("mem_addr", 32'(mem_addr), off + 32'(c) - 32'd1);
            end else begin
                check("mem_en_off", 32'(mem_en), 32'd0);
            end
            check("busy_on", 32'(busy), 32'd1);
            if (if_valid || ld_valid) begin
                seen = 1'b1;
                check_rsp();
            end
            if (c == drop_c) drop_reqs();
        end
        check("rsp_cycle", 32'(c), exp_err ? 32'd1 : 32'd6);
        drop_reqs();
        @(negedge clk);
        check("busy_off", 32'(busy), 32'd0);
        check("no_valid", 32'(if_valid | ld_valid), 32'd0);
    endtask

    initial begin
        int c;
        int last_c;
        int nrsp;
        for (int i = 0; i < 4096; i++) rom[i] = 8'((i * 7 + 3) ^ (i >> 8));
        rom[16] = 8'h11; rom[17] = 8'h22; rom[18] = 8'h33; rom[19] = 8'h44;
        rst_n = 1'b0; if_req = 1'b0; ld_req = 1'b0;
        if_addr = 32'd0; ld_addr = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_valid", 32'({if_valid, if_err, ld_valid, ld_err}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b0, 32'hBFC00010, 1'b0, 0);
        txn(1'b0, 32'hBFC00013, 1'b0, 0);
        txn(1'b1, 32'hBFC00FFC, 1'b0, 0);
        txn(1'b1, 32'hBFC01000, 1'b1, 0);
        txn(1'b1, 32'h00000000, 1'b1, 0);
        txn(1'b0, 32'hBFC00400, 1'b0, 0);

        txn(1'b0, 32'hBFC00010, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drop_idle", 32'({busy, mem_en, if_valid}), 32'd0);
        end

        // Reset during cycle 3 of a fetch abandons it
        if_req = 1'b1; if_addr = 32'hBFC00020;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_outs", 32'({mem_en, if_valid, if_err, ld_valid, ld_err, busy}), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_rdata", rsp_rdata, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("arst_no_valid", 32'(if_valid), 32'd0);
        end
        rst_n = 1'b1;
        txn(1'b0, 32'hBFC00020, 1'b0, 0);

        // Contention from reset release: fetch, load, fetch, load, 7 cycles apart
        rst_n = 1'b0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'hBFC00010;
        ld_req = 1'b1; ld_addr = 32'hBFC00FFC;
        push_exp(1'b0, 32'hBFC00010, 1'b0);
        push_exp(1'b1, 32'hBFC00FFC, 1'b0);
        push_exp(1'b0, 32'hBFC00010, 1'b0);
        push_exp(1'b1, 32'hBFC00FFC, 1'b0);
        rst_n = 1'b1;
        c = 0; last_c = -1; nrsp = 0;
        while (nrsp < 4 && c < 60) begin
            @(negedge clk);
            c++;
            if (if_valid || ld_valid) begin
                check("cont_spacing", 32'(c - last_c), 32'd7);
                check_rsp();
                last_c = c;
                nrsp++;
            end
        end
        check("cont_count", 32'(nrsp), 32'd4);
        drop_reqs();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
